// File: rtl/xif_offload_pkg.sv
// xif_offload_pkg: shared types and defaults for the eXtension-interface offload issuer.
package xif_offload_pkg;
    localparam int X_ID_WIDTH_DEF  = 4;
    localparam int X_RFR_WIDTH_DEF = 32;
    localparam logic [1:0] ISSUE_MODE_M = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, RESULT} state_t;

    typedef struct packed {
        logic [31:0]                  instr;
        logic [X_ID_WIDTH_DEF-1:0]    id;
        logic [X_RFR_WIDTH_DEF-1:0]   rs0;
        logic [X_RFR_WIDTH_DEF-1:0]   rs1;
    } issue_req_t;
endpackage

// File: rtl/xif_offload_issuer_if.sv
// xif_offload_issuer_if: coprocessor-facing issue, commit and result channels.
interface xif_offload_issuer_if
    import xif_offload_pkg::*;
#(
    parameter int X_ID_WIDTH  = X_ID_WIDTH_DEF,
    parameter int X_RFR_WIDTH = X_RFR_WIDTH_DEF
);
    logic                     issue_valid_o;
    logic                     issue_ready_i;
    logic [31:0]              issue_instr_o;
    logic [X_ID_WIDTH-1:0]    issue_id_o;
    logic [2*X_RFR_WIDTH-1:0] issue_rs_o;
    logic [1:0]               issue_rs_valid_o;
    logic                     issue_accept_i;
    logic                     issue_writeback_i;
    logic                     commit_valid_o;
    logic [X_ID_WIDTH-1:0]    commit_id_o;
    logic                     commit_kill_o;
    logic                     result_valid_i;
    logic                     result_ready_o;
    logic [X_ID_WIDTH-1:0]    result_id_i;
    logic [X_RFR_WIDTH-1:0]   result_data_i;
    logic [4:0]               result_rd_i;
    logic                     result_we_i;

    modport master (
        output issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
               commit_valid_o, commit_id_o, commit_kill_o, result_ready_o,
        input  issue_ready_i, issue_accept_i, issue_writeback_i,
               result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i
    );

    modport slave (
        input  issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o,
               commit_valid_o, commit_id_o, commit_kill_o, result_ready_o,
        output issue_ready_i, issue_accept_i, issue_writeback_i,
               result_valid_i, result_id_i, result_data_i, result_rd_i, result_we_i
    );
endinterface

// File: rtl/xif_offload_issuer.sv
// xif_offload_issuer: single-outstanding core-side initiator for the offload issue/commit/result path.
module xif_offload_issuer
    import xif_offload_pkg::*;
#(
    parameter int X_ID_WIDTH     = X_ID_WIDTH_DEF,
    parameter int X_RFR_WIDTH    = X_RFR_WIDTH_DEF,
    parameter int RESULT_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   off_valid_i,
    output logic                   off_ready_o,
    input  logic [31:0]            off_instr_i,
    input  logic [X_RFR_WIDTH-1:0] off_rs0_i,
    input  logic [X_RFR_WIDTH-1:0] off_rs1_i,
    input  logic                   core_commit_valid_i,
    input  logic                   core_commit_kill_i,
    xif_offload_issuer_if.master   xif,
    output logic                   wb_valid_o,
    output logic [4:0]             wb_rd_o,
    output logic [X_RFR_WIDTH-1:0] wb_data_o,
    output logic                   done_o,
    output logic                   illegal_o,
    output logic                   timeout_o
);
    state_t                 state;
    logic [X_ID_WIDTH-1:0]  id_cnt;
    logic [X_ID_WIDTH-1:0]  id;
    logic [31:0]            instr;
    logic [X_RFR_WIDTH-1:0] rs0;
    logic [X_RFR_WIDTH-1:0] rs1;
    logic                   accept;
    logic                   writeback;
    logic                   issue_valid;
    logic                   result_ready;
    logic [15:0]            tmo_cnt;
    logic                   commit_fire;
    logic                   result_hit;

    // The commit is decoded from registered state so a decision already present on COMMIT entry goes out at once.
    assign commit_fire = state == COMMIT && core_commit_valid_i;
    assign result_hit  = state == RESULT && xif.result_valid_i && xif.result_id_i == id;

    assign xif.issue_valid_o    = issue_valid;
    assign xif.issue_instr_o    = instr;
    assign xif.issue_id_o       = id;
    assign xif.issue_rs_o       = {rs1, rs0};
    assign xif.issue_rs_valid_o = 2'b11;
    assign xif.commit_valid_o   = commit_fire;
    assign xif.commit_id_o      = id;
    assign xif.commit_kill_o    = commit_fire && core_commit_kill_i;
    assign xif.result_ready_o   = result_ready;
    assign illegal_o            = commit_fire && !accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            id_cnt       <= '0;
            id           <= '0;
            instr        <= '0;
            rs0          <= '0;
            rs1          <= '0;
            accept       <= 1'b0;
            writeback    <= 1'b0;
            issue_valid  <= 1'b0;
            result_ready <= 1'b0;
            tmo_cnt      <= '0;
            off_ready_o  <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            done_o     <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    off_ready_o <= 1'b1;
                    if (off_valid_i && off_ready_o) begin
                        instr       <= off_instr_i;
                        rs0         <= off_rs0_i;
                        rs1         <= off_rs1_i;
                        id          <= id_cnt;
                        issue_valid <= 1'b1;
                        off_ready_o <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: if (xif.issue_ready_i) begin
                    accept      <= xif.issue_accept_i;
                    writeback   <= xif.issue_writeback_i;
                    id_cnt      <= id_cnt + 1'b1;
                    issue_valid <= 1'b0;
                    state       <= COMMIT;
                end
                COMMIT: if (core_commit_valid_i) begin
                    if (!accept || core_commit_kill_i || !writeback) begin
                        done_o      <= accept;
                        off_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        result_ready <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= RESULT;
                    end
                end
                RESULT: begin
                    if (result_hit) begin
                        wb_valid_o   <= xif.result_we_i;
                        wb_rd_o      <= xif.result_rd_i;
                        wb_data_o    <= xif.result_data_i;
                        done_o       <= 1'b1;
                        result_ready <= 1'b0;
                        off_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end else if (tmo_cnt == 16'(RESULT_TIMEOUT - 1)) begin
                        timeout_o    <= 1'b1;
                        result_ready <= 1'b0;
                        off_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
